mem_initiator: RTL
==================

Name: mem_initiator

Overview:
Bus initiator for the synchronous 8x32 memory, which is the responder on the same memory interface. It accepts burst read/write requests on a valid/ready port and drives read, write, addr and data_in toward the memory. It captures data_out from the memory and returns read data on a response port. It sits between test or system logic and the memory instance.

Parameters:
ADDR_W, 5, memory address width (32 locations)
DATA_W, 8, memory data width
LEN_W, 3, burst length field width; beats = req_len + 1 (1..8)

Ports:
clk  input  1  bus clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  initiator can accept a request
req_write  input  1  1 = write burst, 0 = read burst
req_addr  input  ADDR_W  start address
req_len  input  LEN_W  beats minus one
req_wdata  input  DATA_W  write data for the current beat
wdata_pop  output  1  pulse: req_wdata consumed, present next beat
rsp_valid  output  1  one-cycle pulse per read beat, no backpressure
rsp_rdata  output  DATA_W  read data
rsp_addr  output  ADDR_W  address of the returned beat
rsp_last  output  1  final beat of burst
mem_read  output  1  to memory read
mem_write  output  1  to memory write
mem_addr  output  ADDR_W  to memory addr
mem_data_in  output  DATA_W  to memory data_in
mem_data_out  input  DATA_W  from memory data_out

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=0 during reset, 1 in the first cycle after release; all other outputs 0.
- All mem_* outputs are registered. mem_read and mem_write are never 1 together (hard invariant).
- Handshake: a request is accepted on the edge where req_valid && req_ready. req_ready=1 only in IDLE. Address and length are latched at acceptance.
- States:
  - IDLE: on acceptance, go to WR (write) or RD (read).
  - WR: drive mem_write=1, mem_addr=current address, mem_data_in=req_wdata; pulse wdata_pop. The first beat's req_wdata is sampled at acceptance. Each beat takes one cycle. After the last beat, go to IDLE with mem_write=0.
  - RD: drive mem_read=1, mem_addr=current address. The memory updates data_out on that edge; the initiator samples mem_data_out one edge later. Go to CAP.
  - CAP: mem_read=0. On exit, register rsp_valid=1 with rsp_rdata=mem_data_out and rsp_addr. Return to RD if beats remain, else go to IDLE with rsp_last=1.
- Read latency: request acceptance at edge E0 gives rsp_valid high after edge E0+2 per beat (non-pipelined). A read burst occupies 2*(len+1) cycles.
- Address increments by 1 per beat, modulo 2^ADDR_W: 31 wraps to 0.
- Read after write: issuing a read in the cycle after a write to the same address returns the new data. The memory commits writes before the next edge.
- Reset mid-burst: abort immediately, with no further pulses; mem_read and mem_write drop to 0 asynchronously.
- req_valid while busy: held by the requester, not accepted until IDLE.

Optional Feature:
MEM_INIT_RD_PIPE_EN
- Defined: read beats are pipelined. mem_read stays 1 across consecutive beats with the address advancing each cycle. rsp_valid follows each beat two cycles after its issue, and a burst of N beats completes in N+2 cycles. CAP becomes a drain state that covers the trailing response.
- Undefined: the two-cycle-per-beat RD/CAP alternation described above.

Decomposition:
- Package mem_init_pkg holds:
  - state enum (IDLE, WR, RD, CAP)
  - ADDR_W, DATA_W and LEN_W defaults
  - a request struct typedef (write, addr, len)
- No sub-module. Beat counter, address counter and FSM form a single module (about 200 lines).

Test Plan:
- Write len=0, addr=5, wdata=8'hA5 -> mem_write high exactly 1 cycle with mem_addr=5; the memory location later reads back A5.
- Write burst len=3 at addr=30, data 11,22,33,44 -> mem_addr sequence 30,31,0,1; four wdata_pop pulses; mem_read stays 0 throughout.
- Read burst len=3 at addr=30 after the above -> rsp_rdata 11,22,33,44 with rsp_addr 30,31,0,1. rsp_last is set on beat 4 only. Spacing is 2 cycles per beat (1 cycle with MEM_INIT_RD_PIPE_EN).
- Write addr=7 data=3C, then an immediate read addr=7 -> rsp_rdata=3C, first response 2 cycles after read acceptance.
- Assert rst_n=0 during beat 2 of an 8-beat read -> outputs zero immediately, no further rsp_valid, req_ready=1 one cycle after release.
- Every cycle of every test: checker confirms mem_read && mem_write never holds, and req_ready=0 whenever not IDLE.

Source files
------------

// File: rtl/mem_init_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mem_init_pkg : shared state encoding, default widths and request type.    |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package mem_init_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    CAP  = 2'd3
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_LEN_W-1:0]  len;
  } req_t;

endpackage
`default_nettype wire

// File: rtl/mem_initiator.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mem_initiator : burst read/write initiator for the 8x32 synchronous       |
// | memory. `define MEM_INIT_RD_PIPE_EN pipelines read beats. Rev 1.0         |
// +---------------------------------------------------------------------------+
module mem_initiator
  import mem_init_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              wdata_pop,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_last,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  left_q, left_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
  logic              last_q, last_d;
  logic              wdata_pop_q, wdata_pop_d;
  logic              ready_q;
  logic              p1_valid_q, p1_last_q;
  logic [ADDR_W-1:0] p1_addr_q;
  logic              rsp_valid_q, rsp_last_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [ADDR_W-1:0] rsp_addr_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    left_d        = left_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    last_d        = 1'b0;
    wdata_pop_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          mem_addr_d = req_addr;
          addr_d     = ADDR_W'(req_addr + 1'b1);
          left_d     = req_len;
          last_d     = (req_len == '0);
          if (req_write) begin
            state_d       = WR;
            mem_write_d   = 1'b1;
            mem_data_in_d = req_wdata;
            wdata_pop_d   = 1'b1;
          end else begin
            state_d    = RD;
            mem_read_d = 1'b1;
          end
        end
      end
      WR: begin
        if (left_q != '0) begin
          mem_write_d   = 1'b1;
          mem_addr_d    = addr_q;
          mem_data_in_d = req_wdata;
          wdata_pop_d   = 1'b1;
          addr_d        = ADDR_W'(addr_q + 1'b1);
          left_d        = LEN_W'(left_q - 1'b1);
        end else begin
          state_d = IDLE;
        end
      end
`ifdef MEM_INIT_RD_PIPE_EN
      RD: begin
        // Keep issuing back-to-back; CAP only drains the in-flight beats.
        if (left_q != '0) begin
          mem_read_d = 1'b1;
          mem_addr_d = addr_q;
          addr_d     = ADDR_W'(addr_q + 1'b1);
          left_d     = LEN_W'(left_q - 1'b1);
          last_d     = (left_q == LEN_W'(1));
        end else begin
          state_d = CAP;
        end
      end
      CAP: state_d = IDLE;
`else
      RD:  state_d = CAP;
      CAP: begin
        if (left_q != '0) begin
          state_d    = RD;
          mem_read_d = 1'b1;
          mem_addr_d = addr_q;
          addr_d     = ADDR_W'(addr_q + 1'b1);
          left_d     = LEN_W'(left_q - 1'b1);
          last_d     = (left_q == LEN_W'(1));
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      left_q        <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      last_q        <= 1'b0;
      wdata_pop_q   <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      left_q        <= left_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      last_q        <= last_d;
      wdata_pop_q   <= wdata_pop_d;
      ready_q       <= (state_d == IDLE);
    end
  end

  // Memory updates data_out on the edge after a read issue; sample one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid_q  <= 1'b0;
      p1_addr_q   <= '0;
      p1_last_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_addr_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      p1_valid_q  <= mem_read_q;
      p1_addr_q   <= mem_addr_q;
      p1_last_q   <= mem_read_q & last_q;
      rsp_valid_q <= p1_valid_q;
      rsp_last_q  <= p1_last_q;
      if (p1_valid_q) begin
        rsp_rdata_q <= mem_data_out;
        rsp_addr_q  <= p1_addr_q;
      end
    end
  end

  assign req_ready   = ready_q;
  assign wdata_pop   = wdata_pop_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_last    = rsp_last_q;

endmodule
`default_nettype wire
